// File: rtl/memory_access_unit.sv
// memory_access_unit: byte-serial load/store engine between a word-wide register side and a byte-wide memory
// Ports: Clock/Reset (sync, active-high); Start/WR/NumBytes/Addr/WData request, sampled only while idle;
//   RData assembled load result, Busy, Done one-cycle completion pulse;
//   Mem_Address/Mem_Data/Mem_WR/Mem_CS drive the memory, MemOut is its read byte one cycle after the address.
// Define MEMORY_ACCESS_UNIT_SIGN_EXT_EN to sign-extend short loads; otherwise the upper lanes are zero-filled.
module memory_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  WR,
  input  logic [3:0]            NumBytes,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] WData,
  output logic [DATA_WIDTH-1:0] RData,
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [7:0]            Mem_Data,
  output logic                  Mem_WR,
  output logic                  Mem_CS,
  input  logic [7:0]            MemOut
);
  localparam int BYTES = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, STORE, LOAD_ISSUE, LOAD_DRAIN} stateType;
  stateType state, nextState;
  logic [3:0] idx, lastIdx, effN;
  logic [DATA_WIDTH-1:0] wordShift, loadWord;
  logic [7:0] lanes [BYTES];
  logic [7:0] fill;
  logic last;
  assign Busy = state != IDLE;
  assign last = idx == lastIdx;
  // Zero and oversize counts both mean a full-width transfer.
  assign effN = (NumBytes == 4'd0 || NumBytes > 4'(BYTES)) ? 4'(BYTES) : NumBytes;
`ifdef MEMORY_ACCESS_UNIT_SIGN_EXT_EN
  // The last byte is on MemOut during the drain cycle, so its top bit is the sign.
  assign fill = {8{MemOut[7]}};
`else
  assign fill = 8'h00;
`endif
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else state <= nextState;
  end
  always_comb begin
    nextState = state;
    case (state)
      IDLE:       nextState = Start ? (WR ? STORE : LOAD_ISSUE) : IDLE;
      STORE:      nextState = last ? IDLE : STORE;
      LOAD_ISSUE: nextState = last ? LOAD_DRAIN : LOAD_ISSUE;
      default:    nextState = IDLE;
    endcase
  end
  // Memory outputs are registered: the byte for index idx is on the bus while idx is current.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx         <= '0;
      lastIdx     <= '0;
      wordShift   <= '0;
      Mem_Address <= '0;
      Mem_Data    <= '0;
      Mem_CS      <= 1'b0;
      Mem_WR      <= 1'b0;
      Done        <= 1'b0;
      RData       <= '0;
    end else begin
      Done <= (state == STORE && last) || state == LOAD_DRAIN;
      if (state == IDLE && Start) begin
        idx         <= '0;
        lastIdx     <= effN - 4'd1;
        Mem_Address <= Addr;
        Mem_CS      <= 1'b1;
        Mem_WR      <= WR;
        wordShift   <= WData >> 8;
        if (WR) Mem_Data <= WData[7:0];
      end else if (state == STORE || state == LOAD_ISSUE) begin
        if (last) begin
          Mem_CS <= 1'b0;
          Mem_WR <= 1'b0;
        end else begin
          idx         <= idx + 4'd1;
          Mem_Address <= Mem_Address + ADDR_WIDTH'(1);
          wordShift   <= wordShift >> 8;
          if (state == STORE) Mem_Data <= wordShift[7:0];
        end
      end
      if (state == LOAD_DRAIN) RData <= loadWord;
    end
  end
  // While index idx is issued, MemOut carries byte idx-1; byte N-1 arrives in the drain cycle
  // and is taken straight from MemOut when RData is written.
  for (genvar i = 0; i < BYTES; i++) begin : gLane
    always_ff @(posedge Clock) begin
      if (Reset) lanes[i] <= '0;
      else if (state == LOAD_ISSUE && idx == 4'(i + 1)) lanes[i] <= MemOut;
    end
    assign loadWord[8*i +: 8] = 4'(i) < lastIdx ? lanes[i] : (4'(i) == lastIdx ? MemOut : fill);
  end
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed self-checking bench for memory_access_unit with a byte-wide memory model
module tb_memory_access_unit;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        WR = 1'b0;
  logic [3:0]  NumBytes = '0;
  logic [15:0] Addr = '0;
  logic [31:0] WData = '0;
  logic [31:0] RData;
  logic        Busy, Done, Mem_WR, Mem_CS;
  logic [15:0] Mem_Address;
  logic [7:0]  Mem_Data;
  logic [7:0]  MemOut = '0;
  logic [7:0]  mem [0:65535];
  int memCycles = 0;
  int checks = 0;
  int failures = 0;
  int lat, cyc0;
  logic seen;
`ifdef MEMORY_ACCESS_UNIT_SIGN_EXT_EN
  localparam logic [63:0] EXP2 = 64'hFFFF8534;
  localparam logic [63:0] EXP1 = 64'hFFFFFF80;
`else
  localparam logic [63:0] EXP2 = 64'h00008534;
  localparam logic [63:0] EXP1 = 64'h00000080;
`endif

  memory_access_unit dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .WR(WR), .NumBytes(NumBytes),
    .Addr(Addr), .WData(WData), .RData(RData), .Busy(Busy), .Done(Done),
    .Mem_Address(Mem_Address), .Mem_Data(Mem_Data), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MemOut(MemOut)
  );

  always #5 Clock = ~Clock;

  // Synchronous-read memory: data for an address appears the cycle after it is presented.
  always @(posedge Clock) begin
    if (Mem_CS && !Mem_WR) MemOut <= mem[Mem_Address];
    if (Mem_CS && Mem_WR) mem[Mem_Address] = Mem_Data;
    if (Mem_CS) memCycles <= memCycles + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called one cycle after Start was dropped; lat counts cycles from the Start cycle.
  task automatic waitDone(output int l);
    l = -1;
    for (int k = 2; k <= 30 && l < 0; k++) begin
      @(negedge Clock);
      if (Done) l = k;
    end
  endtask

  task automatic runOp(input logic w, input logic [3:0] nb, input logic [15:0] a,
                       input logic [31:0] wd, output int l);
    @(negedge Clock);
    Start = 1'b1; WR = w; NumBytes = nb; Addr = a; WData = wd;
    @(negedge Clock);
    Start = 1'b0;
    waitDone(l);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[16'(a)] = 8'h00;
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
    mem[16'h0020] = 8'h34; mem[16'h0021] = 8'h85;
    mem[16'h0030] = 8'h01; mem[16'h0031] = 8'h02; mem[16'h0032] = 8'h7F;
    mem[16'h0038] = 8'h80;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("rstBusy", 64'(Busy), 64'h0);
    check("rstDone", 64'(Done), 64'h0);
    check("rstRData", 64'(RData), 64'h0);
    check("rstCS", 64'(Mem_CS), 64'h0);
    check("rstWR", 64'(Mem_WR), 64'h0);
    check("rstAddr", 64'(Mem_Address), 64'h0);
    check("rstData", 64'(Mem_Data), 64'h0);

    // Reset during byte 2 of a 4-byte store.
    @(negedge Clock);
    Start = 1'b1; WR = 1'b1; NumBytes = 4'd4; Addr = 16'h0070; WData = 32'h11223344;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("abortByte2", 64'(Mem_Address), 64'h0072);
    cyc0 = memCycles;
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abortCS", 64'(Mem_CS), 64'h0);
    check("abortBusy", 64'(Busy), 64'h0);
    check("abortRData", 64'(RData), 64'h0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge Clock);
      if (Done || Mem_CS) seen = 1'b1;
    end
    check("abortQuiet", 64'(seen), 64'h0);
    check("abortCycles", 64'(memCycles - cyc0), 64'h1);
    check("abortByte1", 64'(mem[16'h0071]), 64'h33);
    check("abortByte3", 64'(mem[16'h0073]), 64'h00);

    // Full-width store straddling a 256-byte boundary.
    cyc0 = memCycles;
    runOp(1'b1, 4'd4, 16'h00FE, 32'hA1B2C3D4, lat);
    check("st4Lat", 64'(lat), 64'd5);
    check("st4B0", 64'(mem[16'h00FE]), 64'hD4);
    check("st4B1", 64'(mem[16'h00FF]), 64'hC3);
    check("st4B2", 64'(mem[16'h0100]), 64'hB2);
    check("st4B3", 64'(mem[16'h0101]), 64'hA1);
    check("st4Below", 64'(mem[16'h00FD]), 64'h00);
    check("st4Above", 64'(mem[16'h0102]), 64'h00);
    check("st4Cycles", 64'(memCycles - cyc0), 64'd4);
    check("st4IdleCS", 64'(Mem_CS), 64'h0);
    check("st4IdleWR", 64'(Mem_WR), 64'h0);
    check("st4HoldAddr", 64'(Mem_Address), 64'h0101);
    check("st4HoldData", 64'(Mem_Data), 64'hA1);
    check("st4RData", 64'(RData), 64'h0);

    // Loads: zero, short, single, and oversize counts.
    runOp(1'b0, 4'd0, 16'h0010, 32'h0, lat);
    check("ld0Lat", 64'(lat), 64'd6);
    check("ld0RData", 64'(RData), 64'h44332211);
    runOp(1'b0, 4'd2, 16'h0020, 32'h0, lat);
    check("ld2Lat", 64'(lat), 64'd4);
    check("ld2RData", 64'(RData), EXP2);
    runOp(1'b0, 4'd1, 16'h0038, 32'h0, lat);
    check("ld1Lat", 64'(lat), 64'd3);
    check("ld1RData", 64'(RData), EXP1);
    runOp(1'b0, 4'd3, 16'h0030, 32'h0, lat);
    check("ld3Lat", 64'(lat), 64'd5);
    check("ld3RData", 64'(RData), 64'h007F0201);
    runOp(1'b0, 4'd12, 16'h0010, 32'h0, lat);
    check("ldBigLat", 64'(lat), 64'd6);
    check("ldBigRData", 64'(RData), 64'h44332211);

    // Single-byte store leaves RData alone.
    runOp(1'b1, 4'd1, 16'h0040, 32'h1234565A, lat);
    check("st1Lat", 64'(lat), 64'd2);
    check("st1B0", 64'(mem[16'h0040]), 64'h5A);
    check("st1B1", 64'(mem[16'h0041]), 64'h00);
    check("st1RData", 64'(RData), 64'h44332211);

    // Address wrap at the top of the space.
    runOp(1'b1, 4'd2, 16'hFFFF, 32'h0000BEEF, lat);
    check("wrapLat", 64'(lat), 64'd3);
    check("wrapB0", 64'(mem[16'hFFFF]), 64'hEF);
    check("wrapB1", 64'(mem[16'h0000]), 64'hBE);

    // Start held into the busy period is ignored; Start in the Done cycle is accepted.
    cyc0 = memCycles;
    @(negedge Clock);
    Start = 1'b1; WR = 1'b1; NumBytes = 4'd3; Addr = 16'h0050; WData = 32'h00CCBBAA;
    @(negedge Clock);
    Addr = 16'h0060; WData = 32'hFFFFFFFF;
    check("b2bBusy1", 64'(Busy), 64'h1);
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("b2bDone1", 64'(Done), 64'h1);
    check("b2bCycles1", 64'(memCycles - cyc0), 64'd3);
    check("b2bB0", 64'(mem[16'h0050]), 64'hAA);
    check("b2bB2", 64'(mem[16'h0052]), 64'hCC);
    check("b2bIgnored", 64'(mem[16'h0060]), 64'h00);
    Start = 1'b1; WR = 1'b0; NumBytes = 4'd3; Addr = 16'h0030;
    @(negedge Clock);
    Start = 1'b0;
    check("b2bBusy2", 64'(Busy), 64'h1);
    waitDone(lat);
    check("b2bLat2", 64'(lat), 64'd5);
    check("b2bRData", 64'(RData), 64'h007F0201);
    check("b2bCycles2", 64'(memCycles - cyc0), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register-side word width; SHALL be a multiple of 8, range 16..64.
REQ-002 Parameter ADDR_WIDTH, default 16, byte-address width.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request strobe, sampled only while Busy=0.
REQ-006 WR  input  1  1=store, 0=load; sampled with Start.
REQ-007 NumBytes  input  4  bytes to transfer, sampled with Start.
REQ-008 Addr  input  ADDR_WIDTH  start byte address, sampled with Start.
REQ-009 WData  input  DATA_WIDTH  store data, sampled with Start.
REQ-010 RData  output  DATA_WIDTH  assembled load result.
REQ-011 Busy  output  1  transfer in progress.
REQ-012 Done  output  1  one-cycle completion pulse.
REQ-013 Mem_Address  output  ADDR_WIDTH  byte address to memory.
REQ-014 Mem_Data  output  8  byte to memory.
REQ-015 Mem_WR  output  1  1=write cycle.
REQ-016 Mem_CS  output  1  1=memory selected this cycle.
REQ-017 MemOut  input  8  memory read byte, valid the cycle after its address is presented with Mem_CS=1, Mem_WR=0.

Function
REQ-018 Effective count N = NumBytes if 1..DATA_WIDTH/8, else DATA_WIDTH/8 (0 and oversize both mean full width).
REQ-019 Byte order little-endian: byte i goes to/from Addr+i and word bits [8i+7:8i].
REQ-020 Address increment wraps modulo 2^ADDR_WIDTH.
REQ-021 States: IDLE, STORE, LOAD_ISSUE, LOAD_DRAIN; Start=1 in IDLE moves to STORE (WR=1) or LOAD_ISSUE (WR=0) on the next edge.
REQ-022 STORE: one byte per cycle, Mem_CS=1, Mem_WR=1, bytes 0..N-1 in order; after byte N-1 return to IDLE with Done=1 the following cycle.
REQ-023 LOAD_ISSUE: one address per cycle, Mem_CS=1, Mem_WR=0, bytes 0..N-1; each returning MemOut is captured into byte lane i one cycle after issue.
REQ-024 LOAD_DRAIN: one cycle, Mem_CS=0, captures byte N-1, then IDLE with Done=1.
REQ-025 Latency Start-to-Done: store N+1 cycles, load N+2 cycles.
REQ-026 RData updates only on load completion (same cycle Done rises) and holds until the next load completes; stores never change RData.
REQ-027 Lanes above N-1 in RData follow REQ-037/REQ-038.
REQ-028 Busy=1 in STORE, LOAD_ISSUE, LOAD_DRAIN; 0 in IDLE.
REQ-029 Start while Busy=1 ignored, no queuing.
REQ-030 Start in the cycle Done=1 is accepted (Busy=0 then); back-to-back transfers have no bubble beyond the Done cycle.
REQ-031 In IDLE: Mem_CS=0, Mem_WR=0; Mem_Address and Mem_Data hold last value.

Reset
REQ-032 Reset SHALL take priority over Start and any state.
REQ-033 On reset: state IDLE, Busy=0, Done=0, RData=0, Mem_CS=0, Mem_WR=0, Mem_Address=0, Mem_Data=0.
REQ-034 Reset mid-transfer aborts: no further memory cycle issued from the cycle after the reset edge, no Done pulse, RData not updated.

Configuration
REQ-035 Macro MEMORY_ACCESS_UNIT_SIGN_EXT_EN selects load extension.
REQ-036 Applies only to lanes N..DATA_WIDTH/8-1 of a load result.
REQ-037 Defined: upper lanes filled with bit 7 of byte N-1 (sign extension).
REQ-038 Undefined: upper lanes filled with zero.

Verification
REQ-039 Store DATA_WIDTH=32, Addr=0x00FE, WData=0xA1B2C3D4, NumBytes=4 -> writes D4@00FE, C3@00FF, B2@0100, A1@0101; Done 5 cycles after Start.
REQ-040 Load NumBytes=0 from bytes 11,22,33,44 at 0x0010 -> RData=0x44332211, Done 6 cycles after Start.
REQ-041 Load NumBytes=2, bytes 0x34,0x85 -> RData=0xFFFF8534 with macro, 0x00008534 without.
REQ-042 Start pulsed during Busy, then in Done cycle -> first ignored, second accepted, Busy high next cycle, no extra memory cycles.
REQ-043 Reset asserted during byte 2 of 4-byte store -> Mem_CS=0 from next cycle, no Done, Busy=0, RData unchanged at 0.
REQ-044 Store at Addr=0xFFFF, ADDR_WIDTH=16, NumBytes=2 -> bytes at 0xFFFF then 0x0000.
